// File: rtl/fib_pkg.sv
// fib_pkg: shared Fibonacci state enum, sequence seeds F0/F1 and max_index(width) helper
package fib_pkg;
  typedef enum logic {IDLE, SEARCH} state_t;
  localparam int F0 = 0;
  localparam int F1 = 1;
  function automatic int max_index(input int w);
    longint a = 0;
    longint b = 1;
    longint t;
    int l = 0;
    while (a < (longint'(1) << w) - 1) begin
      t = a + b;
      a = b;
      b = t;
      l++;
    end
    return l;
  endfunction
endpackage

// File: rtl/fib_seq_gen.sv
// fib_seq_gen: registered Fibonacci pair; ports clk,rst,load(cur=F0,nxt=F1),adv(cur<=nxt,nxt<=cur+nxt) -> cur,nxt
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         adv,
  output logic [W-1:0] cur,
  output logic [W-1:0] nxt
);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cur <= '0;
      nxt <= '0;
    end else if (load) begin
      cur <= W'(F0);
      nxt <= W'(F1);
    end else if (adv) begin
      cur <= nxt;
      nxt <= cur + nxt;
    end
endmodule

// File: rtl/fib_index_finder.sv
// fib_index_finder: smallest L with F(L)>=in_value plus exact flag; ports clk,rst,in_valid/in_value/in_ready -> out_valid/out_level/out_exact
module fib_index_finder
  import fib_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int LVL_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_value,
  output logic             in_ready,
  output logic             out_valid,
  output logic [LVL_W-1:0] out_level,
  output logic             out_exact
);
  state_t state, state_nx;
  logic [WIDTH-1:0] target;
  logic [LVL_W-1:0] lvl;
  logic [WIDTH:0] cur, nxt;
  logic accept, hit;
  assign accept = in_valid && state == IDLE;
  assign hit = state == SEARCH && cur >= {1'b0, target};
  fib_seq_gen #(.W(WIDTH + 1)) u_seq (
    .clk (clk),
    .rst (rst),
    .load(accept),
    .adv (state == SEARCH && !hit),
    .cur (cur),
    .nxt (nxt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb
    state_nx = state == IDLE ? (in_valid ? SEARCH : IDLE) :
               state == SEARCH ? (hit ? IDLE : SEARCH) : IDLE;
  always_comb in_ready = state == IDLE;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      target    <= '0;
      lvl       <= '0;
      out_valid <= 1'b0;
      out_level <= '0;
      out_exact <= 1'b0;
    end else begin
      out_valid <= hit;
      if (accept) begin
        target <= in_value;
        lvl    <= '0;
      end else if (state == SEARCH && !hit) lvl <= lvl + LVL_W'(1);
      if (hit) begin
        out_level <= lvl;
        out_exact <= cur == {1'b0, target};
      end
    end
endmodule

// File: tb/tb_fib_index_finder.sv
// tb_fib_index_finder: scoreboard bench for fib_index_finder (WIDTH=8)
module tb_fib_index_finder;
  logic clk = 0;
  logic rst = 1;
  logic in_valid = 0;
  logic [7:0] in_value = 0;
  logic in_ready, out_valid, out_exact;
  logic [7:0] out_level;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  typedef struct {int lvl; int ex; int acc;} exp_t;
  exp_t q[$];

  fib_index_finder #(.WIDTH(8), .LVL_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_value (in_value),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_level(out_level),
    .out_exact(out_exact)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", n, a, e);
    end
  endtask

  function automatic void ref_model(input int v, output int l, output int ex);
    int a = 0;
    int b = 1;
    int t;
    l = 0;
    while (a < v) begin
      t = a + b;
      a = b;
      b = t;
      l++;
    end
    ex = (a == v) ? 1 : 0;
  endfunction

  always @(negedge clk)
    if (!rst && out_valid) begin
      if (q.size() == 0) chk("stray_out_valid", 1, 0);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("level", int'(out_level), e.lvl);
        chk("exact", int'(out_exact), e.ex);
        chk("latency", cyc - e.acc, e.lvl + 1);
      end
    end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 0, 1);
  endtask

  task automatic send(input int v, input int l, input int ex);
    wait_ready();
    in_valid = 1;
    in_value = 8'(v);
    q.push_back('{l, ex, cyc + 1});
    @(negedge clk);
    in_valid = 0;
    chk("busy_after_accept", int'(in_ready), 0);
  endtask

  initial begin
    int order[256];
    int l, ex, n;
    #12;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_level", int'(out_level), 0);
    chk("rst_out_exact", int'(out_exact), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst = 0;
    send(0, 0, 1);
    send(1, 1, 1);
    send(4, 5, 0);
    send(233, 13, 1);
    send(255, 14, 0);
    send(8, 6, 1);
    in_valid = 1;
    in_value = 3;
    chk("ready_in_search", int'(in_ready), 0);
    @(negedge clk);
    in_valid = 0;
    send(3, 4, 1);
    wait_ready();
    in_valid = 1;
    in_value = 100;
    @(posedge clk);
    @(negedge clk);
    in_valid = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_out_level", int'(out_level), 0);
    chk("arst_out_exact", int'(out_exact), 0);
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("ready_after_rst", int'(in_ready), 1);
    send(2, 3, 1);
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 255; i > 0; i--) begin
      int j, t;
      j = int'($urandom_range(i, 0));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      ref_model(order[i], l, ex);
      send(order[i], l, ex);
    end
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    chk("pending_results", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
